gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer: RTL and testbench
==========================================================

# gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer

Staged reset-release controller for banks of `dffrnq` flops. It drives the active-low `RN` pins of up to `N_DOM` flop domains and releases them one domain at a time, with a programmed gap between releases. The gap keeps `RN`→`CLK` recovery/removal margins and limits simultaneous-release current. It sits between the chip-level synchronous reset and the standard-cell register banks, and supports a handshaked soft re-reset.

## Interface
- `N_DOM`, default 4: number of reset domains, ≥1.
- `HOLD_CYC`, default 4: cycles all `RN` stay low before the first release, ≥1.
- `GAP_CYC`, default 2: idle cycles between consecutive domain releases (or assertions), ≥0.
- `CLK` input 1: the single clock. All logic is on its rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `SRST_REQ` input 1: soft-reset request, a level.
- `SRST_ACK` output 1: one-cycle pulse when a request is accepted.
- `RN` output `N_DOM`: active-low domain resets, registered, driven straight to flop `RN` pins.
- `DONE` output 1: high when all domains are released.
- `STAGE` output `$clog2(N_DOM+1)`: number of domains currently released.

## Operation
- **Reset values:** `RN`=0 for all bits, `DONE`=0, `SRST_ACK`=0, `STAGE`=0. State is HOLD with the counter loaded to `HOLD_CYC-1`.
- **States:** HOLD, REL, GAP, RUN, ASSERT. ASSERT exists only with the macro.
- **HOLD:** count down. At zero, set `RN[0]`=1 and go to GAP, or to RUN if `N_DOM`=1.
- **GAP:** count `GAP_CYC` cycles, then REL. With `GAP_CYC`=0, REL is immediate.
- **REL:** release the next domain in ascending index order and increment `STAGE`. After `RN[N_DOM-1]` is released, go to RUN.
- **RUN:** `DONE`=1. This is the only state in which `SRST_REQ` is sampled.
- **Soft-reset acceptance:** when `SRST_REQ`=1 in RUN:
  - `SRST_ACK`=1 for exactly that one cycle, and `DONE`=0.
  - The requester must drop `SRST_REQ` after seeing `SRST_ACK`.
  - A request still high on return to RUN is accepted again.
- `SRST_REQ` in any state other than RUN is ignored; no ACK is issued.
- **Counter:** one down-counter of width `$clog2(max(HOLD_CYC,GAP_CYC)+1)`. It is reloaded on every state entry and never wraps.
- **Mid-operation `RST`:** `RST`=1 at any edge overrides everything, including a pending ACK. Outputs return to their reset values on that edge.

## Timing
- Edge 0 is the first rising edge with `RST`=0.
- `RN[i]` rises at edge `HOLD_CYC-1 + i*(GAP_CYC+1)`.
- `DONE` rises one edge after `RN[N_DOM-1]`.
- Defaults: `RN[0..3]` rise at edges 3, 6, 9, 12; `DONE` at 13.
- `RN` is never released out of index order, and never two bits on the same edge unless `GAP_CYC`=0 (even then, one per edge).
- Once released, an `RN` bit only falls through `RST` or soft-reset.
- Soft-reset without the macro: on the acceptance edge, `RN`=0, `STAGE`=0, HOLD loaded. The release schedule then repeats, with the acceptance edge treated as edge −1.

## Configuration
- **Macro:** `GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN`.
- **Defined:**
  - Soft-reset enters ASSERT.
  - `RN[N_DOM-1]` falls on the acceptance edge, then each lower index falls `GAP_CYC+1` edges later. `STAGE` decrements at each fall.
  - After `RN[0]` falls, go to HOLD. Schedule from there as above.
- **Undefined:** all bits fall together on the acceptance edge, and the ASSERT state and its logic are absent.
- `RST` assertion is always simultaneous for all bits, regardless of the macro.

## Structure
- **Package `gf180mcu_rstseq_pkg`:**
  - state enum (HOLD, REL, GAP, RUN, ASSERT);
  - a width function for the counter and `STAGE`.
- **Sub-module `gf180mcu_rstseq_cnt`:** the loadable down-counter, with `zero` flag output. The FSM and the `RN` shift logic stay in the top.

## Test plan
- **Power-on:** defaults, `RST` high for 3 cycles then low → `RN` 0001 at edge 3, 0011 at 6, 0111 at 9, 1111 at 12; `DONE`=1 at 13; `STAGE`=4.
- **Early soft-reset:** `SRST_REQ` raised at edge 5 and held → no ACK until edge 13. ACK is one cycle at edge 13, `RN`=0000 at 13. Requester drops REQ at 14; re-release `RN[0]` at edge 17.
- **Mid-sequence `RST`:** `RST`=1 at edge 7 (`RN`=0011) → `RN`=0000, `STAGE`=0 at edge 7. The sequence restarts from the next low edge.
- **Zero gap:** `GAP_CYC`=0, `HOLD_CYC`=1, `N_DOM`=3 → `RN` 001, 011, 111 at edges 0, 1, 2; `DONE` at 3.
- **Staggered assert (macro on):** defaults, soft-reset accepted at edge T → `RN` 0111 at T, 0011 at T+3, 0001 at T+6, 0000 at T+9. Then HOLD; `RN[0]` rises at T+9+`HOLD_CYC`.
- **Single domain:** `N_DOM`=1 → `RN[0]` rises at edge 3, `DONE` at 4. A held `SRST_REQ` produces an ACK every re-entry to RUN.

Source files
------------

// File: rtl/gf180mcu_rstseq_pkg.sv
// Shared types and width helpers for the staged RN reset sequencer.
// ST_ASSERT exists only when GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN is defined.
package gf180mcu_rstseq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_REL,
    ST_GAP,
    ST_RUN
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
    , ST_ASSERT
`endif
  } state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..v inclusive; never less than one.
  function automatic int w_of(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_rstseq_cnt.sv
// Loadable saturating down-counter; stops at zero and reports it through a flag.
module gf180mcu_rstseq_cnt #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= RST_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer.sv
// Staged RN release for dffrnq banks with handshaked soft re-reset.
// Define GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN to stagger soft-reset assertion top-down.
module gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer
  import gf180mcu_rstseq_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         SRST_REQ,
  output logic                         SRST_ACK,
  output logic [N_DOM-1:0]             RN,
  output logic                         DONE,
  output logic [w_of(N_DOM)-1:0]       STAGE
);

  localparam int CW = w_of(max_i(HOLD_CYC, GAP_CYC));
  localparam int SW = w_of(N_DOM);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
  // ASSERT waits one extra edge per step, so it reloads the full gap.
  localparam logic [CW-1:0] GAP_FULL = CW'(GAP_CYC);
`endif

  state_t            state_reg;
  logic [N_DOM-1:0]  rn_reg;
  logic [SW-1:0]     stage_reg;
  logic              done_reg;
  logic              ack_reg;

  logic              cnt_load;
  logic [CW-1:0]     cnt_val;
  logic              cnt_zero;
  logic [N_DOM-1:0]  rn_up;

  // Released domains always form a contiguous low-index run.
  assign rn_up = (rn_reg << 1) | N_DOM'(1);
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
  logic [N_DOM-1:0]  rn_dn;
  assign rn_dn = rn_reg >> 1;
`endif

  gf180mcu_rstseq_cnt #(
    .W       (CW),
    .RST_VAL (HOLD_LD)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_reg)
      ST_HOLD: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = GAP_LD;
      end
      ST_GAP: if (cnt_zero) begin
        cnt_load = 1'b1;
      end
      ST_REL: begin
        cnt_load = 1'b1;
        cnt_val  = GAP_LD;
      end
      ST_RUN: if (SRST_REQ) begin
        cnt_load = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
        cnt_val  = (N_DOM == 1) ? HOLD_LD : GAP_FULL;
`else
        cnt_val  = HOLD_LD;
`endif
      end
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
      ST_ASSERT: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = (stage_reg == SW'(1)) ? HOLD_LD : GAP_FULL;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_HOLD;
      rn_reg    <= '0;
      stage_reg <= '0;
      done_reg  <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        ST_HOLD: if (cnt_zero) begin
          rn_reg    <= rn_up;
          stage_reg <= stage_reg + SW'(1);
          if (N_DOM == 1)        state_reg <= ST_RUN;
          else if (GAP_CYC == 0) state_reg <= ST_REL;
          else                   state_reg <= ST_GAP;
        end
        ST_GAP: if (cnt_zero) begin
          state_reg <= ST_REL;
        end
        ST_REL: begin
          rn_reg    <= rn_up;
          stage_reg <= stage_reg + SW'(1);
          if (stage_reg == SW'(N_DOM - 1)) state_reg <= ST_RUN;
          else if (GAP_CYC == 0)           state_reg <= ST_REL;
          else                             state_reg <= ST_GAP;
        end
        ST_RUN: begin
          if (SRST_REQ) begin
            ack_reg  <= 1'b1;
            done_reg <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
            rn_reg    <= rn_dn;
            stage_reg <= stage_reg - SW'(1);
            state_reg <= (N_DOM == 1) ? ST_HOLD : ST_ASSERT;
`else
            rn_reg    <= '0;
            stage_reg <= '0;
            state_reg <= ST_HOLD;
`endif
          end else begin
            done_reg <= 1'b1;
          end
        end
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
        ST_ASSERT: if (cnt_zero) begin
          rn_reg    <= rn_dn;
          stage_reg <= stage_reg - SW'(1);
          if (stage_reg == SW'(1)) state_reg <= ST_HOLD;
        end
`endif
        default: state_reg <= ST_HOLD;
      endcase
    end
  end

  assign RN       = rn_reg;
  assign DONE     = done_reg;
  assign STAGE    = stage_reg;
  assign SRST_ACK = ack_reg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer.sv
// Directed bench: default, zero-gap and single-domain sequencers share one clock and RST.
module tb_gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst;
  logic       req_d, req_z, req_1;
  logic       ack_d, ack_z, ack_1;
  logic       done_d, done_z, done_1;
  logic [3:0] rn_d;
  logic [2:0] rn_z;
  logic [0:0] rn_1;
  logic [2:0] stage_d;
  logic [1:0] stage_z;
  logic [0:0] stage_1;

  int vectors     = 0;
  int miscompares = 0;
  int e           = 0;

  gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer dut_d (
    .CLK(CLK), .RST(rst), .SRST_REQ(req_d), .SRST_ACK(ack_d),
    .RN(rn_d), .DONE(done_d), .STAGE(stage_d)
  );

  gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer #(.N_DOM(3), .HOLD_CYC(1), .GAP_CYC(0)) dut_z (
    .CLK(CLK), .RST(rst), .SRST_REQ(req_z), .SRST_ACK(ack_z),
    .RN(rn_z), .DONE(done_z), .STAGE(stage_z)
  );

  gf180mcu_fd_sc_mcu7t5v0__rstn_sequencer #(.N_DOM(1)) dut_1 (
    .CLK(CLK), .RST(rst), .SRST_REQ(req_1), .SRST_ACK(ack_1),
    .RN(rn_1), .DONE(done_1), .STAGE(stage_1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
    e++;
  endtask

  task automatic tick_to(input int n);
    while (e < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @e%0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    e = -1;
  endtask

  initial begin
    rst = 1'b1; req_d = 1'b0; req_z = 1'b0; req_1 = 1'b0;
    repeat (3) tick();
    chk("rst_rn_d",    32'(rn_d),    32'h0);
    chk("rst_done_d",  32'(done_d),  32'h0);
    chk("rst_ack_d",   32'(ack_d),   32'h0);
    chk("rst_stage_d", 32'(stage_d), 32'h0);
    chk("rst_rn_z",    32'(rn_z),    32'h0);
    chk("rst_rn_1",    32'(rn_1),    32'h0);

    // Power-on release schedule
    rst = 1'b0; e = -1;
    tick_to(0);  chk("A_rn_z", 32'(rn_z), 32'h1);
    tick_to(1);  chk("A_rn_z", 32'(rn_z), 32'h3);
    tick_to(2);  chk("A_rn_d", 32'(rn_d), 32'h0);
                 chk("A_rn_z", 32'(rn_z), 32'h7);
                 chk("A_done_z", 32'(done_z), 32'h0);
    tick_to(3);  chk("A_rn_d", 32'(rn_d), 32'h1);
                 chk("A_stage_d", 32'(stage_d), 32'h1);
                 chk("A_done_z", 32'(done_z), 32'h1);
                 chk("A_stage_z", 32'(stage_z), 32'h3);
                 chk("A_rn_1", 32'(rn_1), 32'h1);
                 chk("A_done_1", 32'(done_1), 32'h0);
    tick_to(4);  chk("A_done_1", 32'(done_1), 32'h1);
    tick_to(5);  chk("A_rn_d", 32'(rn_d), 32'h1);
    tick_to(6);  chk("A_rn_d", 32'(rn_d), 32'h3);
                 chk("A_stage_d", 32'(stage_d), 32'h2);
    tick_to(8);  chk("A_rn_d", 32'(rn_d), 32'h3);
    tick_to(9);  chk("A_rn_d", 32'(rn_d), 32'h7);
    tick_to(12); chk("A_rn_d", 32'(rn_d), 32'hF);
                 chk("A_done_d", 32'(done_d), 32'h0);
    tick_to(13); chk("A_done_d", 32'(done_d), 32'h1);
                 chk("A_stage_d", 32'(stage_d), 32'h4);
                 chk("A_ack_d", 32'(ack_d), 32'h0);
    req_d = 1'b1;
    tick_to(14); chk("A_ack_d", 32'(ack_d), 32'h1);
                 chk("A_done_d", 32'(done_d), 32'h0);
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
                 chk("A_rn_d", 32'(rn_d), 32'h7);
                 chk("A_stage_d", 32'(stage_d), 32'h3);
`else
                 chk("A_rn_d", 32'(rn_d), 32'h0);
                 chk("A_stage_d", 32'(stage_d), 32'h0);
`endif
    req_d = 1'b0;
    tick_to(15); chk("A_ack_d", 32'(ack_d), 32'h0);
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
    tick_to(16); chk("A_rn_d", 32'(rn_d), 32'h7);
    tick_to(17); chk("A_rn_d", 32'(rn_d), 32'h3);
                 chk("A_stage_d", 32'(stage_d), 32'h2);
    tick_to(20); chk("A_rn_d", 32'(rn_d), 32'h1);
    tick_to(22); chk("A_rn_d", 32'(rn_d), 32'h1);
    tick_to(23); chk("A_rn_d", 32'(rn_d), 32'h0);
                 chk("A_stage_d", 32'(stage_d), 32'h0);
    tick_to(26); chk("A_rn_d", 32'(rn_d), 32'h0);
    tick_to(27); chk("A_rn_d", 32'(rn_d), 32'h1);
`else
    tick_to(17); chk("A_rn_d", 32'(rn_d), 32'h0);
    tick_to(18); chk("A_rn_d", 32'(rn_d), 32'h1);
`endif

    // Early soft-reset request on default; held request on single domain
    do_reset();
    req_1 = 1'b1;
    tick_to(3);  chk("B_rn_1", 32'(rn_1), 32'h1);
                 chk("B_ack_1", 32'(ack_1), 32'h0);
    tick_to(4);  chk("B_ack_1", 32'(ack_1), 32'h1);
                 chk("B_done_1", 32'(done_1), 32'h0);
                 chk("B_rn_1", 32'(rn_1), 32'h0);
    tick_to(5);  chk("B_ack_1", 32'(ack_1), 32'h0);
    req_d = 1'b1;
    tick_to(8);  chk("B_ack_d", 32'(ack_d), 32'h0);
                 chk("B_rn_1", 32'(rn_1), 32'h1);
                 chk("B_ack_1", 32'(ack_1), 32'h0);
    tick_to(9);  chk("B_ack_1", 32'(ack_1), 32'h1);
    req_1 = 1'b0;
    tick_to(12); chk("B_ack_d", 32'(ack_d), 32'h0);
                 chk("B_rn_d", 32'(rn_d), 32'hF);
    tick_to(13); chk("B_ack_d", 32'(ack_d), 32'h1);
                 chk("B_done_d", 32'(done_d), 32'h0);
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
                 chk("B_rn_d", 32'(rn_d), 32'h7);
`else
                 chk("B_rn_d", 32'(rn_d), 32'h0);
                 chk("B_stage_d", 32'(stage_d), 32'h0);
`endif
    req_d = 1'b0;
    tick_to(14); chk("B_ack_d", 32'(ack_d), 32'h0);
`ifdef GF180MCU_FD_SC_MCU7T5V0_RSTSEQ_STAGGER_ASSERT_EN
    tick_to(16); chk("B_rn_d", 32'(rn_d), 32'h3);
`else
    tick_to(16); chk("B_rn_d", 32'(rn_d), 32'h0);
    tick_to(17); chk("B_rn_d", 32'(rn_d), 32'h1);
`endif

    // RST mid-sequence, colliding with a soft-reset acceptance on zero-gap
    do_reset();
    tick_to(6);  chk("C_rn_d", 32'(rn_d), 32'h3);
                 chk("C_done_z", 32'(done_z), 32'h1);
    rst = 1'b1; req_z = 1'b1;
    tick_to(7);  chk("C_rn_d", 32'(rn_d), 32'h0);
                 chk("C_stage_d", 32'(stage_d), 32'h0);
                 chk("C_ack_z", 32'(ack_z), 32'h0);
                 chk("C_rn_z", 32'(rn_z), 32'h0);
                 chk("C_done_z", 32'(done_z), 32'h0);
    rst = 1'b0; req_z = 1'b0; e = -1;
    tick_to(2);  chk("C_rn_d", 32'(rn_d), 32'h0);
    tick_to(3);  chk("C_rn_d", 32'(rn_d), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
